ps2_pad_keys: RTL and testbench

PS2_PAD_KEYS -- requirements
Module: ps2_pad_keys

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_pad_keys_if.sv | 21 ++
 rtl/ps2_rx.sv | 111 +++++++++++
 rtl/ps2_pad_keys.sv | 124 ++++++++++++
 tb/tb_ps2_pad_keys.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared scancode constants and decoder state type for the PS/2 pad-key block.
package ps2_pkg;

  localparam logic [7:0] SC_W   = 8'h1D;
  localparam logic [7:0] SC_S   = 8'h1B;
  localparam logic [7:0] SC_UP  = 8'h75;
  localparam logic [7:0] SC_DN  = 8'h72;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_t;

endpackage

// File: rtl/ps2_pad_keys_if.sv
// PS/2 input lines and pad-control outputs of ps2_pad_keys.
interface ps2_pad_keys_if;
  logic ps2_clk;
  logic ps2_data;
  logic timing_tick;
  logic up_left;
  logic down_left;
  logic up_right;
  logic down_right;
  logic frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  timing_tick, up_left, down_left, up_right, down_right, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output timing_tick, up_left, down_left, up_right, down_right, frame_err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge sampling, framing checks, timeout.
// Parity checking is compiled in only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx #(
  parameter int TIMEOUT_CYC = 65_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_prev;
  logic          fall;
  logic          bit_in;
  logic [3:0]    bit_cnt;
  logic          start_bit;
  logic [7:0]    data_sr;
  logic [TW-1:0] tmr;
  logic          tmr_tc;
  logic          parity_bad;
  logic          frame_bad;

  // Reset to 1 so an idle bus does not look like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = dat_sync[1];
  assign tmr_tc = (tmr == TW'(1));

`ifdef PS2_PARITY_CHECK_EN
  logic par_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
    end else if (fall) begin
      if (bit_cnt == 4'd0)
        par_acc <= 1'b0;
      else if (bit_cnt <= 4'd9)
        par_acc <= par_acc ^ bit_in;
    end
  end

  // Data plus parity must hold an odd number of ones.
  assign parity_bad = ~par_acc;
`else
  assign parity_bad = 1'b0;
`endif

  // Evaluated on the 11th edge, where bit_in is the stop bit.
  assign frame_bad = start_bit | ~bit_in | parity_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= 4'd0;
      start_bit  <= 1'b0;
      data_sr    <= 8'h00;
      tmr        <= '0;
      code       <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tmr <= TMR_LOAD;
        if (bit_cnt == 4'd0)
          start_bit <= bit_in;
        if ((bit_cnt >= 4'd1) && (bit_cnt <= 4'd8))
          data_sr <= {bit_in, data_sr[7:1]};
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_bad) begin
            frame_err <= 1'b1;
          end else begin
            code       <= data_sr;
            code_valid <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (tmr_tc) begin
          bit_cnt   <= 4'd0;
          frame_err <= 1'b1;
        end else begin
          tmr <= tmr - TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_pad_keys.sv
// Keyboard-to-pad controller: scancode decode, four key flags, registered pad
// outputs and a free-running movement tick. Build option: PS2_PARITY_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for a scancode or prefix
// EXT     | E0 seen, next code is an extended make (or F0)
// BRK     | F0 seen, next code is a break
// EXT_BRK | E0 F0 seen, next code is an extended break
module ps2_pad_keys
  import ps2_pkg::*;
#(
  parameter int TICK_DIV    = 650_000,
  parameter int TIMEOUT_CYC = 65_000
) (
  input logic           clk,
  input logic           rst_n,
  ps2_pad_keys_if.slave bus
);

  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

  logic [7:0]     code;
  logic           code_valid;
  kbd_state_t     state, state_nxt;
  logic           key_w, key_s, key_up, key_dn;
  logic           key_w_nxt, key_s_nxt, key_up_nxt, key_dn_nxt;
  logic [TCW-1:0] tick_cnt;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .code       (code),
    .code_valid (code_valid),
    .frame_err  (bus.frame_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    key_w_nxt  = key_w;
    key_s_nxt  = key_s;
    key_up_nxt = key_up;
    key_dn_nxt = key_dn;
    if (code_valid) begin
      unique case (state)
        IDLE: begin
          if (code == SC_EXT) begin
            state_nxt = EXT;
          end else if (code == SC_BRK) begin
            state_nxt = BRK;
          end else begin
            if (code == SC_W) key_w_nxt = 1'b1;
            if (code == SC_S) key_s_nxt = 1'b1;
          end
        end
        EXT: begin
          if (code == SC_BRK) begin
            state_nxt = EXT_BRK;
          end else begin
            state_nxt = IDLE;
            if (code == SC_UP) key_up_nxt = 1'b1;
            if (code == SC_DN) key_dn_nxt = 1'b1;
          end
        end
        BRK: begin
          state_nxt = IDLE;
          if (code == SC_W) key_w_nxt = 1'b0;
          if (code == SC_S) key_s_nxt = 1'b0;
        end
        EXT_BRK: begin
          state_nxt = IDLE;
          if (code == SC_UP) key_up_nxt = 1'b0;
          if (code == SC_DN) key_dn_nxt = 1'b0;
        end
      endcase
    end
  end

  // Opposing keys held together cancel to no movement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_w          <= 1'b0;
      key_s          <= 1'b0;
      key_up         <= 1'b0;
      key_dn         <= 1'b0;
      bus.up_left    <= 1'b0;
      bus.down_left  <= 1'b0;
      bus.up_right   <= 1'b0;
      bus.down_right <= 1'b0;
    end else begin
      key_w          <= key_w_nxt;
      key_s          <= key_s_nxt;
      key_up         <= key_up_nxt;
      key_dn         <= key_dn_nxt;
      bus.up_left    <= key_w & ~key_s;
      bus.down_left  <= key_s & ~key_w;
      bus.up_right   <= key_up & ~key_dn;
      bus.down_right <= key_dn & ~key_up;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt        <= '0;
      bus.timing_tick <= 1'b0;
    end else begin
      bus.timing_tick <= (tick_cnt == TICK_LAST);
      if (tick_cnt == TICK_LAST)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + TCW'(1);
    end
  end

endmodule

// File: tb/tb_ps2_pad_keys.sv
// Bench for ps2_pad_keys: directed make/break, extended, conflict, parity,
// timeout and tick steps, then random scancode traffic against a key-state model.
module tb_ps2_pad_keys;
  import ps2_pkg::*;

  localparam int TICK = 4;
  localparam int TOUT = 200;
  localparam int H    = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_pad_keys_if bus ();

  ps2_pad_keys #(.TICK_DIV(TICK), .TIMEOUT_CYC(TOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int err_seen    = 0;
  int exp_err     = 0;
  int tcyc        = 0;
  int tick_bad    = 0;

  bit m_w, m_s, m_up, m_dn, m_ext, m_brk;
  logic snap_ul, snap_dl, snap_ur, snap_dr;

  always @(posedge clk) begin
    if (!rst_n) begin
      tcyc = 0;
    end else begin
      tcyc++;
      #2;
      if (bus.frame_err === 1'b1) err_seen++;
      if (bus.timing_tick !== ((tcyc % TICK) == 0)) tick_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Key-state model at the scancode-sequence level.
  function automatic void model_byte(input logic [7:0] c);
    if (m_brk) begin
      if (m_ext) begin
        if (c == 8'h75) m_up = 0;
        if (c == 8'h72) m_dn = 0;
      end else begin
        if (c == 8'h1D) m_w = 0;
        if (c == 8'h1B) m_s = 0;
      end
      m_ext = 0;
      m_brk = 0;
    end else if (c == 8'hF0) begin
      m_brk = 1;
    end else if (!m_ext && c == 8'hE0) begin
      m_ext = 1;
    end else begin
      if (m_ext) begin
        if (c == 8'h75) m_up = 1;
        if (c == 8'h72) m_dn = 1;
      end else begin
        if (c == 8'h1D) m_w = 1;
        if (c == 8'h1B) m_s = 1;
      end
      m_ext = 0;
    end
  endfunction

  function automatic void model_clear();
    m_w = 0; m_s = 0; m_up = 0; m_dn = 0; m_ext = 0; m_brk = 0;
  endfunction

  task automatic check_pads(input string tag);
    chk({tag, " up_left"},    bus.up_left,    m_w & ~m_s);
    chk({tag, " down_left"},  bus.down_left,  m_s & ~m_w);
    chk({tag, " up_right"},   bus.up_right,   m_up & ~m_dn);
    chk({tag, " down_right"}, bus.down_right, m_dn & ~m_up);
    chk({tag, " err_count"},  err_seen,       exp_err);
  endtask

  // kind: 0 good, 1 bad start, 2 bad stop, 3 bad parity
  task automatic send_frame(input logic [7:0] c, input int kind, input int nbits);
    logic [10:0] f;
    logic par;
    par = ~(^c);
    if (kind == 3) par = ^c;
    f = {(kind == 2) ? 1'b0 : 1'b1, par, c, (kind == 1) ? 1'b1 : 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = f[i];
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (6) @(negedge clk);
        snap_ul = bus.up_left;
        snap_dl = bus.down_left;
        snap_ur = bus.up_right;
        snap_dr = bus.down_right;
        repeat (H - 6) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] c);
    send_frame(c, 0, 11);
    model_byte(c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pool [8];
    logic [7:0] c;
    int kind;
    pool = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'h1C, 8'h00};
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    model_clear();

    // Reset state and tick cadence
    repeat (2) @(negedge clk);
    chk("rst tick", bus.timing_tick, 0);
    chk("rst frame_err", bus.frame_err, 0);
    check_pads("rst");
    rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      chk($sformatf("tick cyc%0d", k), bus.timing_tick, (k % TICK) == 0);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("tick in reset", bus.timing_tick, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("tick restart cyc%0d", k), bus.timing_tick, (k % TICK) == 0);
    end

    // Make then break W
    send_good(8'h1D);
    chk("make_w within 6clk", snap_ul, 1);
    check_pads("make_w");
    send_good(8'hF0);
    send_good(8'h1D);
    check_pads("break_w");

    // Extended down arrow
    send_good(8'hE0);
    send_good(8'h72);
    chk("ext make down_right", bus.down_right, 1);
    check_pads("ext_make");
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h72);
    check_pads("ext_break");
    chk("fsm idle", 32'(dut.state), 32'(IDLE));

    // Conflicting W and S
    send_good(8'h1D);
    send_good(8'h1B);
    check_pads("conflict");
    send_good(8'hF0);
    send_good(8'h1D);
    chk("conflict release", bus.down_left, 1);
    check_pads("conflict_release");
    send_good(8'hF0);
    send_good(8'h1B);

    // Wrong parity on W
    send_frame(8'h1D, 3, 11);
`ifdef PS2_PARITY_CHECK_EN
    exp_err++;
`else
    model_byte(8'h1D);
`endif
    check_pads("parity");
    send_good(8'hF0);
    send_good(8'h1D);

    // Stall mid-frame, then a clean S
    send_frame(8'h55, 0, 5);
    repeat (TOUT + 100) @(negedge clk);
    exp_err++;
    chk("timeout err", err_seen, exp_err);
    send_good(8'h1B);
    check_pads("after_timeout");

    // Framing errors leave keys unchanged
    send_frame(8'h1D, 1, 11);
    exp_err++;
    check_pads("bad_start");
    send_frame(8'h1D, 2, 11);
    exp_err++;
    check_pads("bad_stop");

    // Reset mid-frame abandons silently
    send_frame(8'h1D, 0, 6);
    do_reset();
    repeat (TOUT + 50) @(negedge clk);
    check_pads("reset_midframe");
    send_good(8'h1D);
    check_pads("post_reset");

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      c = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 7)];
      kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (kind == 0) begin
        send_good(c);
      end else begin
        send_frame(c, kind, 11);
        exp_err++;
      end
      check_pads($sformatf("rand%0d", n));
    end

    chk("tick independent", tick_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
